// File: rtl/glb_rd_if.sv
// Bundle between the GLB read arbiter and the lane controllers plus GLB port:
// per-lane read requests/addresses in, one shared GLB read port, permit pulses out.
interface glb_rd_if #(
    parameter int NUM_IF = 32,
    parameter int NUM_IP = 32
);
    logic [NUM_IF-1:0]        ifmap_glb_read_req_i;
    logic [NUM_IF-1:0][31:0]  ifmap_glb_read_addr_i;
    logic [NUM_IP-1:0]        ipsum_glb_read_req_i;
    logic [NUM_IP-1:0][31:0]  ipsum_glb_read_addr_i;
    logic                     glb_busy_i;
    logic                     glb_rd_en_o;
    logic [31:0]              glb_rd_addr_o;
    logic [31:0]              glb_rdata_i;
    logic [NUM_IF-1:0]        ifmap_permit_push_o;
    logic [NUM_IP-1:0]        ipsum_permit_push_o;
    logic [31:0]              rdata_o;

    modport master (
        input  ifmap_glb_read_req_i,
        input  ifmap_glb_read_addr_i,
        input  ipsum_glb_read_req_i,
        input  ipsum_glb_read_addr_i,
        input  glb_busy_i,
        input  glb_rdata_i,
        output glb_rd_en_o,
        output glb_rd_addr_o,
        output ifmap_permit_push_o,
        output ipsum_permit_push_o,
        output rdata_o
    );

    modport slave (
        output ifmap_glb_read_req_i,
        output ifmap_glb_read_addr_i,
        output ipsum_glb_read_req_i,
        output ipsum_glb_read_addr_i,
        output glb_busy_i,
        output glb_rdata_i,
        input  glb_rd_en_o,
        input  glb_rd_addr_o,
        input  ifmap_permit_push_o,
        input  ipsum_permit_push_o,
        input  rdata_o
    );
endinterface

// File: rtl/glb_rd_arbiter.sv
// Round-robin arbiter over the ifmap+ipsum lane read requests onto the single GLB
// read port; returns each word to its lane as a one-cycle permit pulse.
module glb_rd_arbiter #(
    parameter int NUM_IF = 32,
    parameter int NUM_IP = 32,
    parameter int RD_LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    glb_rd_if.master  bus
);
    localparam int NUM_TOT = NUM_IF + NUM_IP;
    localparam int ID_W    = $clog2(NUM_TOT);

    logic [NUM_TOT-1:0]        req_all;
    logic [NUM_TOT-1:0][31:0]  addr_all;
    logic [NUM_TOT-1:0]        inflight_reg, inflight_next;
    logic [NUM_TOT-1:0]        ret_mask, eligible, grant_mask;
    logic [ID_W-1:0]           rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]           grant_id, ret_id;
    logic [ID_W:0]             scan_idx;
    logic                      grant_found, issue, ret_valid;
    logic [RD_LAT-1:0]         pipe_valid_reg;
    logic [ID_W-1:0]           pipe_id_reg [RD_LAT];

    // Unified index space: ifmap lanes low, ipsum lanes above them.
    assign req_all  = {bus.ipsum_glb_read_req_i, bus.ifmap_glb_read_req_i};
    assign addr_all = {bus.ipsum_glb_read_addr_i, bus.ifmap_glb_read_addr_i};

    assign ret_valid = pipe_valid_reg[RD_LAT-1];
    assign ret_id    = pipe_id_reg[RD_LAT-1];
    assign ret_mask  = ret_valid ? (NUM_TOT'(1) << ret_id) : '0;

    // A lane whose permit is pulsing now is still in flight for this cycle.
    assign eligible = req_all & ~inflight_reg & ~ret_mask;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_TOT; i++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(NUM_TOT)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_TOT);
            end
            if (!grant_found && eligible[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    assign issue      = grant_found & ~bus.glb_busy_i;
    assign grant_mask = issue ? (NUM_TOT'(1) << grant_id) : '0;

    assign bus.glb_rd_en_o         = issue;
    assign bus.glb_rd_addr_o       = issue ? addr_all[grant_id] : 32'd0;
    assign bus.ifmap_permit_push_o = ret_mask[NUM_IF-1:0];
    assign bus.ipsum_permit_push_o = ret_mask[NUM_TOT-1:NUM_IF];
    assign bus.rdata_o             = ret_valid ? bus.glb_rdata_i : 32'd0;

    always_comb begin
        inflight_next = (inflight_reg & ~ret_mask) | grant_mask;
        rr_ptr_next   = rr_ptr_reg;
        if (issue) begin
            rr_ptr_next = (grant_id == ID_W'(NUM_TOT-1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg   <= '0;
            inflight_reg <= '0;
        end else begin
            rr_ptr_reg   <= rr_ptr_next;
            inflight_reg <= inflight_next;
        end
    end

    // Return pipeline: stage RD_LAT-1 lines up with valid GLB read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_id_reg[i] <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= issue;
            pipe_id_reg[0]    <= grant_id;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_id_reg[i]    <= pipe_id_reg[i-1];
            end
        end
    end
endmodule

// File: tb/tb_glb_rd_arbiter.sv
// Drives two arbiters (read latency 1 and 3) with the same directed/random stimulus
// and checks them against a lane-level reference model plus literal expectations.
module tb_glb_rd_arbiter;
    localparam int NT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req;
    logic [31:0] addr [NT];
    logic        busy;
    logic [31:0] rdata_in;

    always #5 clk = ~clk;

    glb_rd_if #(.NUM_IF(32), .NUM_IP(32)) if1 ();
    glb_rd_if #(.NUM_IF(32), .NUM_IP(32)) if3 ();

    assign if1.ifmap_glb_read_req_i = req[31:0];
    assign if1.ipsum_glb_read_req_i = req[63:32];
    assign if3.ifmap_glb_read_req_i = req[31:0];
    assign if3.ipsum_glb_read_req_i = req[63:32];
    assign if1.glb_busy_i  = busy;
    assign if3.glb_busy_i  = busy;
    assign if1.glb_rdata_i = rdata_in;
    assign if3.glb_rdata_i = rdata_in;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_addr
            assign if1.ifmap_glb_read_addr_i[gi] = addr[gi];
            assign if1.ipsum_glb_read_addr_i[gi] = addr[32+gi];
            assign if3.ifmap_glb_read_addr_i[gi] = addr[gi];
            assign if3.ipsum_glb_read_addr_i[gi] = addr[32+gi];
        end
    endgenerate

    glb_rd_arbiter #(.NUM_IF(32), .NUM_IP(32), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    glb_rd_arbiter #(.NUM_IF(32), .NUM_IP(32), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic        en_a   [2];
    logic [31:0] addr_a [2];
    logic [63:0] perm_a [2];
    logic [31:0] rd_a   [2];

    assign en_a[0]   = if1.glb_rd_en_o;
    assign addr_a[0] = if1.glb_rd_addr_o;
    assign perm_a[0] = {if1.ipsum_permit_push_o, if1.ifmap_permit_push_o};
    assign rd_a[0]   = if1.rdata_o;
    assign en_a[1]   = if3.glb_rd_en_o;
    assign addr_a[1] = if3.glb_rd_addr_o;
    assign perm_a[1] = {if3.ipsum_permit_push_o, if3.ifmap_permit_push_o};
    assign rd_a[1]   = if3.rdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each lane is either idle or waiting for data due at a given cycle.
    int pend_due [2][NT];
    int rr [2];
    int lat [2];
    bit model_ok = 1'b0;
    int cyc = 0;

    initial begin
        lat[0] = 1;
        lat[1] = 3;
    end

    always @(negedge clk) begin : model
        int          ret;
        int          g;
        int          k;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [63:0] exp_perm;
        logic [31:0] exp_rd;
        for (int d = 0; d < 2; d++) begin
            ret = -1;
            for (int j = 0; j < NT; j++) begin
                if (pend_due[d][j] == cyc) ret = j;
            end
            g = -1;
            for (int i = 0; i < NT; i++) begin
                k = (rr[d] + i) % NT;
                if (g < 0 && req[k] && pend_due[d][k] < 0) g = k;
            end
            exp_en   = (g >= 0) && !busy;
            exp_addr = exp_en ? addr[g] : 32'd0;
            exp_perm = (ret >= 0) ? (64'd1 << ret) : 64'd0;
            exp_rd   = (ret >= 0) ? rdata_in : 32'd0;
            if (model_ok) begin
                chk($sformatf("lat%0d rd_en c%0d", lat[d], cyc), {63'd0, en_a[d]}, {63'd0, exp_en});
                chk($sformatf("lat%0d rd_addr c%0d", lat[d], cyc), {32'd0, addr_a[d]}, {32'd0, exp_addr});
                chk($sformatf("lat%0d permit c%0d", lat[d], cyc), perm_a[d], exp_perm);
                chk($sformatf("lat%0d rdata c%0d", lat[d], cyc), {32'd0, rd_a[d]}, {32'd0, exp_rd});
            end
            if (rst) begin
                rr[d] = 0;
                for (int j = 0; j < NT; j++) pend_due[d][j] = -1;
            end else if (model_ok) begin
                if (ret >= 0) pend_due[d][ret] = -1;
                if (exp_en) begin
                    pend_due[d][g] = cyc + lat[d];
                    rr[d] = (g + 1) % NT;
                end
            end
        end
        if (rst) model_ok = 1'b1;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rdata_in = $urandom;
    endtask

    task automatic do_reset();
        req  = '0;
        busy = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    task automatic drain(input int n);
        req = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        busy     = 1'b0;
        rdata_in = 32'h0;
        for (int k = 0; k < NT; k++) begin
            addr[k] = (k < 32) ? 32'h1000 + 32'(k) * 4 : 32'h2000 + 32'(k - 32) * 4;
        end
        addr[3] = 32'h100;
        tick();
        tick();
        rst = 1'b0;
        rdata_in = 32'hDEADBEEF;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset rd_en", {63'd0, en_a[d]}, 64'd0);
            chk("reset rd_addr", {32'd0, addr_a[d]}, 64'd0);
            chk("reset permit", perm_a[d], 64'd0);
            chk("reset rdata", {32'd0, rd_a[d]}, 64'd0);
        end

        // Single request, lane 3
        do_reset();
        req[3] = 1'b1;
        #1;
        chk("single T rd_en", {63'd0, en_a[0]}, 64'd1);
        chk("single T addr", {32'd0, addr_a[0]}, 64'h100);
        tick();
        #1;
        chk("single T+1 permit", perm_a[0], 64'h8);
        chk("single T+1 rdata", {32'd0, rd_a[0]}, {32'd0, rdata_in});
        chk("single T+1 no regrant", {63'd0, en_a[0]}, 64'd0);
        tick();
        #1;
        chk("single T+2 regrant", {32'd0, addr_a[0]}, 64'h100);
        drain(5);

        // Round robin over all 64 lanes
        do_reset();
        req = '1;
        for (int c = 0; c <= 64; c++) begin
            #1;
            chk($sformatf("rr grant %0d", c), {32'd0, addr_a[0]}, {32'd0, addr[c % NT]});
            if (c == 32) chk("rr ipsum0 addr", {32'd0, addr_a[0]}, 64'h2000);
            tick();
        end
        drain(5);

        // Busy stall
        do_reset();
        req[5] = 1'b1;
        req[6] = 1'b1;
        busy   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("busy no rd_en", {63'd0, en_a[0]}, 64'd0);
            chk("busy no permit", perm_a[0], 64'd0);
            tick();
        end
        busy = 1'b0;
        #1;
        chk("busy release lane5", {32'd0, addr_a[0]}, 64'h1014);
        tick();
        #1;
        chk("busy release lane6", {32'd0, addr_a[0]}, 64'h1018);
        drain(5);

        // Latency 3, lane 10
        do_reset();
        req[10] = 1'b1;
        req[11] = 1'b1;
        req[12] = 1'b1;
        req[20] = 1'b1;
        #1;
        chk("lat T grant10", {32'd0, addr_a[1]}, 64'h1028);
        tick();
        #1;
        chk("lat T+1 grant11", {32'd0, addr_a[1]}, 64'h102C);
        chk("lat T+1 no permit", perm_a[1], 64'd0);
        tick();
        #1;
        chk("lat T+2 grant12", {32'd0, addr_a[1]}, 64'h1030);
        chk("lat T+2 no permit", perm_a[1], 64'd0);
        tick();
        #1;
        chk("lat T+3 permit10", perm_a[1], 64'h400);
        chk("lat T+3 grant20", {32'd0, addr_a[1]}, 64'h1050);
        tick();
        #1;
        chk("lat T+4 permit11", perm_a[1], 64'h800);
        chk("lat T+4 regrant10", {32'd0, addr_a[1]}, 64'h1028);
        drain(6);

        // Reset mid-flight
        do_reset();
        req[7] = 1'b1;
        req[8] = 1'b1;
        #1;
        chk("midrst T grant7", {32'd0, addr_a[0]}, 64'h101C);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst T+1 grant8", {32'd0, addr_a[0]}, 64'h1020);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst T+2 no permit lat1", perm_a[0], 64'd0);
        chk("midrst T+2 no permit lat3", perm_a[1], 64'd0);
        chk("midrst T+2 grant7", {32'd0, addr_a[0]}, 64'h101C);
        drain(6);

        // Wrap from pointer 63
        do_reset();
        req[62] = 1'b1;
        tick();
        req     = '0;
        req[63] = 1'b1;
        req[2]  = 1'b1;
        #1;
        chk("wrap grant63 lat1", {32'd0, addr_a[0]}, 64'h207C);
        chk("wrap grant63 lat3", {32'd0, addr_a[1]}, 64'h207C);
        tick();
        #1;
        chk("wrap grant2 lat1", {32'd0, addr_a[0]}, 64'h1008);
        chk("wrap grant2 lat3", {32'd0, addr_a[1]}, 64'h1008);
        drain(6);

        // Mixed traffic with stalls and occasional resets
        for (int c = 0; c < 300; c++) begin
            req  = {$urandom, $urandom} & {$urandom, $urandom};
            busy = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst  = 1'b0;
        busy = 1'b0;
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
